wire_obf_mux_bank: RTL and testbench



---
 rtl/wire_obf_mux_bank.sv | 119 +++++++++++
 tb/tb_wire_obf_mux_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wire_obf_mux_bank.sv
// Key-programmable wire-obfuscation mux bank: NCH channels, each selecting one of
// 2^SELW candidate wires through a serially loaded key with hitless re-keying.
module wire_obf_mux_bank #(
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int REG_OUT = 1
) (
  input  logic                      CK,
  input  logic                      RST_N,
  input  logic [NCH*(2**SELW)-1:0]  CAND,
  input  logic                      KEY_START,
  input  logic                      KEY_VALID,
  input  logic                      KEY_BIT,
  output logic [NCH-1:0]            MUX_O,
  output logic                      KEY_OK,
  output logic                      LOAD_BUSY
);

  localparam int NCAND = 2**SELW;
  localparam int KW    = NCH*SELW;
  localparam int CW    = $clog2(KW+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [KW-1:0]   r_shadow;
  logic [KW-1:0]   r_activeKey;
  logic [KW-1:0]   w_shiftIn;
  logic [CW-1:0]   r_count;
  logic            r_keyOk;
  logic            w_accept;
  logic            w_commit;
  logic [NCH-1:0]  w_mux;
  logic [NCH-1:0]  w_gated;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // KEY_START wins over a same-cycle KEY_VALID, so that bit is never accepted.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE:   if (KEY_START) w_nextState = S_LOAD;
      S_LOAD: begin
        if (KEY_START) begin
          w_nextState = S_LOAD;
        end else if (KEY_VALID) begin
          w_accept = 1'b1;
          if (r_count == CW'(KW-1)) begin
            w_commit    = 1'b1;
            w_nextState = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: if (KEY_START) w_nextState = S_LOAD;
      default:  w_nextState = S_IDLE;
    endcase
  end

  generate
    if (KW == 1) begin : g_shiftOne
      assign w_shiftIn = KEY_BIT;
    end else begin : g_shiftMany
      assign w_shiftIn = {r_shadow[KW-2:0], KEY_BIT};
    end
  endgenerate

  // The active key only changes on commit, which keeps re-keying hitless.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      r_shadow    <= '0;
      r_activeKey <= '0;
      r_count     <= '0;
      r_keyOk     <= 1'b0;
    end else if (KEY_START) begin
      r_shadow <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_shadow <= w_shiftIn;
      if (w_commit) begin
        r_activeKey <= w_shiftIn;
        r_keyOk     <= 1'b1;
        r_count     <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_comb begin
    w_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      w_mux[c] = CAND[c*NCAND + int'(r_activeKey[c*SELW +: SELW])];
    end
    w_gated = r_keyOk ? w_mux : '0;
  end

  generate
    if (REG_OUT != 0) begin : g_regOut
      logic [NCH-1:0] r_muxO;
      always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) r_muxO <= '0;
        else        r_muxO <= w_gated;
      end
      assign MUX_O = r_muxO;
    end else begin : g_combOut
      assign MUX_O = w_gated;
    end
  endgenerate

  assign KEY_OK    = r_keyOk;
  assign LOAD_BUSY = (r_state == S_LOAD);

endmodule

// File: tb/tb_wire_obf_mux_bank.sv
// Scoreboard bench for wire_obf_mux_bank (NCH=4, SELW=2, REG_OUT=1): stimulus pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_wire_obf_mux_bank;

  logic        CK;
  logic        RST_N;
  logic [15:0] CAND;
  logic        KEY_START;
  logic        KEY_VALID;
  logic        KEY_BIT;
  logic [3:0]  MUX_O;
  logic        KEY_OK;
  logic        LOAD_BUSY;

  typedef struct {
    int          due;
    logic [3:0]  mux;
    logic        ok;
    logic        busy;
    string       name;
  } expect_t;

  expect_t sb[$];
  int      cycleCount = 0;
  int      vectors = 0;
  int      miscompares = 0;

  wire_obf_mux_bank #(.NCH(4), .SELW(2), .REG_OUT(1)) dut (
    .CK(CK), .RST_N(RST_N), .CAND(CAND),
    .KEY_START(KEY_START), .KEY_VALID(KEY_VALID), .KEY_BIT(KEY_BIT),
    .MUX_O(MUX_O), .KEY_OK(KEY_OK), .LOAD_BUSY(LOAD_BUSY)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  always @(posedge CK) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [3:0] expMux,
                             input logic expOk, input logic expBusy);
    vectors++;
    if (MUX_O !== expMux || KEY_OK !== expOk || LOAD_BUSY !== expBusy) begin
      miscompares++;
      $display("[TB] FAIL %s: got MUX_O=%h KEY_OK=%b LOAD_BUSY=%b, expected MUX_O=%h KEY_OK=%b LOAD_BUSY=%b",
               name, MUX_O, KEY_OK, LOAD_BUSY, expMux, expOk, expBusy);
    end
  endtask

  // Monitor: every negedge, compare all expectations due in this cycle.
  always @(negedge CK) begin
    expect_t e;
    while (sb.size() > 0 && sb[0].due <= cycleCount) begin
      e = sb.pop_front();
      checkOutput(e.name, e.mux, e.ok, e.busy);
    end
  end

  // Called at posedge+2; the entry is checked at the following negedge.
  task automatic expectNow(input logic [3:0] mux, input logic ok, input logic busy,
                           input string name);
    expect_t e;
    e.due  = cycleCount;
    e.mux  = mux;
    e.ok   = ok;
    e.busy = busy;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic b);
    KEY_START = s;
    KEY_VALID = v;
    KEY_BIT   = b;
    @(posedge CK);
    #2;
  endtask

  task automatic loadKey(input logic [7:0] key, input logic startValid,
                         input int gapAt, input int gapLen,
                         input logic [3:0] oldMux, input logic oldOk,
                         input logic [3:0] newMux, input string name);
    applyStimulus(1'b1, startValid, 1'b1);
    expectNow(oldMux, oldOk, 1'b1, {name, "_start"});
    for (int i = 0; i < 8; i++) begin
      if (i == gapAt) begin
        for (int g = 0; g < gapLen; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b1);
          expectNow(oldMux, oldOk, 1'b1, {name, "_gap"});
        end
      end
      applyStimulus(1'b0, 1'b1, key[7-i]);
      if (i < 7) expectNow(oldMux, oldOk, 1'b1, {name, "_bit"});
      else       expectNow(oldMux, 1'b1, 1'b0, {name, "_commit"});
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectNow(newMux, 1'b1, 1'b0, {name, "_newkey"});
  endtask

  initial begin
    RST_N = 1'b0;
    CAND = 16'hFFFF;
    KEY_START = 1'b0;
    KEY_VALID = 1'b0;
    KEY_BIT = 1'b0;
    #3;
    checkOutput("reset", 4'h0, 1'b0, 1'b0);
    #9 RST_N = 1'b1;
    @(posedge CK); #2;

    // No key loaded: outputs stay 0 even with all candidates high and stray valid bits.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      expectNow(4'h0, 1'b0, 1'b0, "idle_nokey");
    end

    CAND = 16'h8421;
    loadKey(8'hE4, 1'b0, 99, 0, 4'h0, 1'b0, 4'hF, "basic");
    loadKey(8'hE4, 1'b0, 4, 3, 4'hF, 1'b1, 4'hF, "gapped");
    loadKey(8'h00, 1'b0, 99, 0, 4'hF, 1'b1, 4'h1, "rekey");

    // Restart after 5 bits; the bit sampled together with KEY_START is dropped.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectNow(4'h1, 1'b1, 1'b1, "restart_start");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2) == 0);
      expectNow(4'h1, 1'b1, 1'b1, "restart_bit");
    end
    loadKey(8'h1B, 1'b1, 99, 0, 4'h1, 1'b1, 4'h0, "restart");

    // Key 1B selects CAND[3], CAND[6], CAND[9], CAND[12]; one-cycle CAND latency.
    CAND = 16'h0208;
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectNow(4'h5, 1'b1, 1'b0, "cand_0208");
    CAND = 16'h1040;
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectNow(4'hA, 1'b1, 1'b0, "cand_1040");

    // Reset in the middle of a re-key.
    CAND = 16'hFFFF;
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectNow(4'hF, 1'b1, 1'b1, "rstload_start");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      expectNow(4'hF, 1'b1, 1'b1, "rstload_bit");
    end
    KEY_VALID = 1'b0;
    @(negedge CK); #1;
    RST_N = 1'b0;
    #1;
    checkOutput("rstload_async", 4'h0, 1'b0, 1'b0);
    @(negedge CK); #1;
    RST_N = 1'b1;
    @(posedge CK); #2;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      expectNow(4'h0, 1'b0, 1'b0, "after_reset");
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CK);
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
